// File: rtl/spdif_frame_sync.sv
// spdif_frame_sync: biphase-mark interval decoder and subframe sequencer.
// Takes per-edge interval classes (1/2/3 UI) and locks onto B/M/W preambles.
// It assembles each 32-slot subframe into a 24-bit sample with V/U/C, a parity
// check, a channel tag and a block-start tag.
module spdif_frame_sync #(
    parameter int LOCK_SUBFRAMES = 4,
    parameter int TIMEOUT        = 64
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        one_i,
    input  logic        two_i,
    input  logic        three_i,
    input  logic        ena_i,
    output logic [23:0] sample_o,
    output logic        valid_o,
    output logic        chan_o,
    output logic        block_start_o,
    output logic        v_o,
    output logic        u_o,
    output logic        c_o,
    output logic        parity_err_o,
    output logic        locked_o,
    output logic        code_err_o
);

    localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [3:0]        LOCK_MAX = 4'(LOCK_SUBFRAMES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam logic [4:0]        LAST_BIT = 5'd27;

    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        PRE    = 3'd1,
        DATA_H = 3'd2,
        DATA_L = 3'd3,
        SYNC   = 3'd4
    } state_t;

    function automatic logic [3:0] lock_inc(input logic [3:0] v);
        return (v >= LOCK_MAX) ? LOCK_MAX : v + 4'd1;
    endfunction

    function automatic logic [IDLE_W-1:0] idle_inc(input logic [IDLE_W-1:0] v);
        return (v >= IDLE_MAX) ? IDLE_MAX : v + IDLE_W'(1);
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cls_p0;
    logic [1:0]        pre_cnt;
    logic [1:0]        pre_a;
    logic [1:0]        pre_b;
    logic              first;
    logic              cur_w;
    logic              cur_blk;
    logic [4:0]        bit_cnt;
    logic [3:0]        lock_cnt;
    logic [IDLE_W-1:0] idle;
    logic [26:0]       shreg;
    logic              par;

    logic       is_1;
    logic       is_2;
    logic       is_3;
    logic [1:0] cls_code;
    logic       pre_last;
    logic       pre_is_b;
    logic       pre_is_m;
    logic       pre_is_w;
    logic       pre_valid;
    logic       order_ok;
    logic       last_bit;
    logic       timeout;
    logic       publish;

    logic err;
    logic bit_en;
    logic bit_val;
    logic pre_start;
    logic pre_step;
    logic pre_done;
    logic sf_done;

    // Anything other than exactly one class flag is an invalid interval.
    assign is_1     = (cls_p0 == 3'b001);
    assign is_2     = (cls_p0 == 3'b010);
    assign is_3     = (cls_p0 == 3'b100);
    assign cls_code = is_1 ? 2'd1 : is_2 ? 2'd2 : is_3 ? 2'd3 : 2'd0;

    // Preamble patterns after the leading 3-UI interval: B=(1,1,3) M=(3,1,1) W=(2,1,2).
    assign pre_last  = (pre_cnt == 2'd2);
    assign pre_is_b  = (pre_a == 2'd1) && (pre_b == 2'd1) && is_3;
    assign pre_is_m  = (pre_a == 2'd3) && (pre_b == 2'd1) && is_1;
    assign pre_is_w  = (pre_a == 2'd2) && (pre_b == 2'd1) && is_2;
    assign pre_valid = pre_is_b || pre_is_m || pre_is_w;
    // Channels must alternate; the first subframe after HUNT has nothing to compare to.
    assign order_ok  = first || (pre_is_w != cur_w);
    assign last_bit  = (bit_cnt == LAST_BIT);
    assign timeout   = (state != HUNT) && (idle == IDLE_MAX);
    assign publish   = sf_done && (lock_inc(lock_cnt) == LOCK_MAX);
    assign locked_o  = (lock_cnt == LOCK_MAX);

    // State register.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: every violation (or timeout) falls back to HUNT.
    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = HUNT;
        end else if (ena_i) begin
            unique case (state)
                HUNT: begin
                    if (is_3) state_nxt = PRE;
                end
                PRE: begin
                    if (pre_last) state_nxt = (pre_valid && order_ok) ? DATA_H : HUNT;
                end
                DATA_H: begin
                    if (is_2)      state_nxt = last_bit ? SYNC : DATA_H;
                    else if (is_1) state_nxt = DATA_L;
                    else           state_nxt = HUNT;
                end
                DATA_L: begin
                    if (is_1) state_nxt = last_bit ? SYNC : DATA_H;
                    else      state_nxt = HUNT;
                end
                SYNC: begin
                    state_nxt = is_3 ? PRE : HUNT;
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Per-edge control strobes derived from the current state and interval class.
    always_comb begin
        err       = 1'b0;
        bit_en    = 1'b0;
        bit_val   = 1'b0;
        pre_start = 1'b0;
        pre_step  = 1'b0;
        pre_done  = 1'b0;
        sf_done   = 1'b0;
        if (timeout) begin
            err = 1'b1;
        end else if (ena_i) begin
            unique case (state)
                HUNT: begin
                    pre_start = is_3;
                end
                PRE: begin
                    if (!pre_last)                  pre_step = 1'b1;
                    else if (pre_valid && order_ok) pre_done = 1'b1;
                    else                            err      = 1'b1;
                end
                DATA_H: begin
                    if (is_2) begin
                        bit_en  = 1'b1;
                        sf_done = last_bit;
                    end else if (!is_1) begin
                        err = 1'b1;
                    end
                end
                DATA_L: begin
                    if (is_1) begin
                        bit_en  = 1'b1;
                        bit_val = 1'b1;
                        sf_done = last_bit;
                    end else begin
                        err = 1'b1;
                    end
                end
                SYNC: begin
                    if (is_3) pre_start = 1'b1;
                    else      err       = 1'b1;
                end
                default: err = 1'b1;
            endcase
        end
    end

    // Control registers: class latch, preamble collector, bit/lock/idle counters, strobes.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cls_p0     <= 3'b000;
            pre_cnt    <= 2'd0;
            pre_a      <= 2'd0;
            pre_b      <= 2'd0;
            first      <= 1'b0;
            cur_w      <= 1'b0;
            cur_blk    <= 1'b0;
            bit_cnt    <= 5'd0;
            lock_cnt   <= 4'd0;
            idle       <= '0;
            valid_o    <= 1'b0;
            code_err_o <= 1'b0;
        end else begin
            cls_p0     <= {three_i, two_i, one_i};
            idle       <= ena_i ? '0 : idle_inc(idle);
            valid_o    <= publish;
            code_err_o <= err;

            if (pre_start) begin
                pre_cnt <= 2'd0;
            end else if (pre_step) begin
                pre_cnt <= pre_cnt + 2'd1;
                if (pre_cnt == 2'd0) pre_a <= cls_code;
                else                 pre_b <= cls_code;
            end

            if (pre_start && (state == HUNT)) begin
                first <= 1'b1;
            end else if (pre_done) begin
                first <= 1'b0;
            end

            if (pre_done) begin
                cur_w   <= pre_is_w;
                cur_blk <= pre_is_b;
            end

            if (err || pre_done) begin
                bit_cnt <= 5'd0;
            end else if (bit_en) begin
                bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
            end

            if (err) begin
                lock_cnt <= 4'd0;
            end else if (sf_done) begin
                lock_cnt <= lock_inc(lock_cnt);
            end
        end
    end

    // Slot shift register (slots 4..30, first bit ends at index 0) and running parity.
    always_ff @(posedge clk_i) begin
        if (bit_en) begin
            shreg <= {bit_val, shreg[26:1]};
        end
        if (pre_done) begin
            par <= 1'b0;
        end else if (bit_en) begin
            par <= par ^ bit_val;
        end
    end

    // Payload outputs, refreshed only when a completed subframe is published in lock.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sample_o      <= 24'h0;
            v_o           <= 1'b0;
            u_o           <= 1'b0;
            c_o           <= 1'b0;
            parity_err_o  <= 1'b0;
            chan_o        <= 1'b0;
            block_start_o <= 1'b0;
        end else if (publish) begin
            sample_o      <= shreg[23:0];
            v_o           <= shreg[24];
            u_o           <= shreg[25];
            c_o           <= shreg[26];
            parity_err_o  <= par ^ bit_val;
            chan_o        <= cur_w;
            block_start_o <= cur_blk;
        end
    end

endmodule

// File: tb/tb_spdif_frame_sync.sv
// Bench for spdif_frame_sync: directed scenarios plus randomized subframe streams,
// checked every cycle against an interval-list reference model.
module tb_spdif_frame_sync;

    localparam int LOCK = 4;
    localparam int TMO  = 64;
    localparam int PB   = 0;
    localparam int PM   = 1;
    localparam int PW   = 2;

    typedef logic [2:0] iq_t[$];

    logic        clk_i = 1'b0;
    logic        nrst_i = 1'b1;
    logic        one_i = 1'b0;
    logic        two_i = 1'b0;
    logic        three_i = 1'b0;
    logic        ena_i = 1'b0;
    logic [23:0] sample_o;
    logic        valid_o;
    logic        chan_o;
    logic        block_start_o;
    logic        v_o;
    logic        u_o;
    logic        c_o;
    logic        parity_err_o;
    logic        locked_o;
    logic        code_err_o;

    spdif_frame_sync #(.LOCK_SUBFRAMES(LOCK), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .nrst_i(nrst_i), .one_i(one_i), .two_i(two_i), .three_i(three_i),
        .ena_i(ena_i), .sample_o(sample_o), .valid_o(valid_o), .chan_o(chan_o),
        .block_start_o(block_start_o), .v_o(v_o), .u_o(u_o), .c_o(c_o),
        .parity_err_o(parity_err_o), .locked_o(locked_o), .code_err_o(code_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int obs_valid = 0;
    int obs_err = 0;
    bit go = 0;

    // ---------------- reference model ----------------
    bit          m_hunt, m_first, m_await, m_cur_w, m_cur_b;
    int          m_list[$];
    int          m_lock, m_gap, m_prev_cls;
    logic [23:0] e_sample;
    logic        e_valid, e_err, e_locked, e_chan, e_blk, e_v, e_u, e_c, e_perr;

    function automatic int cls_code(input logic [2:0] f);
        case (f)
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 3;
            default: return 0;
        endcase
    endfunction

    task automatic m_reset();
        m_hunt = 1; m_first = 0; m_await = 0; m_cur_w = 0; m_cur_b = 0;
        m_list.delete();
        m_lock = 0; m_gap = 0; m_prev_cls = 0;
        e_sample = 24'h0; e_valid = 0; e_err = 0; e_locked = 0; e_chan = 0;
        e_blk = 0; e_v = 0; e_u = 0; e_c = 0; e_perr = 0;
    endtask

    task automatic m_fail();
        e_err = 1; m_hunt = 1; m_lock = 0; m_await = 0;
        m_list.delete();
    endtask

    task automatic m_accept(input int k);
        logic [27:0] bits;
        int nb, i;
        bit bad, is_b, is_m, is_w;
        if (m_hunt) begin
            if (k == 3) begin
                m_hunt = 0; m_first = 1; m_await = 0;
                m_list.delete(); m_list.push_back(3);
            end
            return;
        end
        if (m_await) begin
            if (k == 3) begin
                m_await = 0; m_list.delete(); m_list.push_back(3);
            end else m_fail();
            return;
        end
        m_list.push_back(k);
        if (m_list.size() == 4) begin
            is_b = (m_list[1] == 1) && (m_list[2] == 1) && (m_list[3] == 3);
            is_m = (m_list[1] == 3) && (m_list[2] == 1) && (m_list[3] == 1);
            is_w = (m_list[1] == 2) && (m_list[2] == 1) && (m_list[3] == 2);
            if (!(is_b || is_m || is_w)) begin m_fail(); return; end
            if (!m_first && (is_w == m_cur_w)) begin m_fail(); return; end
            m_first = 0; m_cur_w = is_w; m_cur_b = is_b;
            return;
        end
        if (m_list.size() < 4) return;
        bits = '0; nb = 0; i = 4; bad = 0;
        while (i < m_list.size() && !bad && nb < 28) begin
            if (m_list[i] == 2) begin
                bits[nb] = 1'b0; nb++; i++;
            end else if (m_list[i] == 1 && i + 1 < m_list.size()) begin
                if (m_list[i+1] == 1) begin bits[nb] = 1'b1; nb++; i += 2; end
                else bad = 1;
            end else if (m_list[i] == 1) begin
                i++;
            end else bad = 1;
        end
        if (bad) m_fail();
        else if (nb == 28) begin
            m_await = 1;
            if (m_lock < LOCK) m_lock++;
            if (m_lock == LOCK) begin
                e_valid = 1; e_sample = bits[23:0];
                e_v = bits[24]; e_u = bits[25]; e_c = bits[26];
                e_perr = ^bits; e_chan = m_cur_w; e_blk = m_cur_b;
            end
        end
    endtask

    task automatic m_step(input bit ena, input int k);
        e_valid = 0; e_err = 0;
        if (!m_hunt && m_gap >= TMO) m_fail();
        else if (ena) m_accept(k);
        m_gap = ena ? 0 : m_gap + 1;
        e_locked = (m_lock == LOCK);
    endtask

    initial begin
        wait (go);
        forever begin
            @(posedge clk_i);
            if (nrst_i) begin
                m_step(ena_i, m_prev_cls);
                m_prev_cls = cls_code({three_i, two_i, one_i});
            end else m_prev_cls = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [32:0] act_v, exp_v;
    initial begin
        wait (go);
        forever begin
            @(posedge clk_i);
            #2;
            act_v = {valid_o, code_err_o, locked_o, chan_o, block_start_o, v_o, u_o, c_o,
                     parity_err_o, sample_o};
            exp_v = {e_valid, e_err, e_locked, e_chan, e_blk, e_v, e_u, e_c, e_perr, e_sample};
            if (valid_o) obs_valid++;
            if (code_err_o) obs_err++;
            n_checks++;
            if (act_v !== exp_v) begin
                n_errors++;
                $display("FAIL cycle_outputs t=%0t got %h expected %h (vld,err,lck,ch,blk,v,u,c,perr,sample)",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [27:0] mk(input logic [23:0] smp, input logic v, input logic u,
                                       input logic c, input logic flip);
        logic [26:0] body;
        body = {c, u, v, smp};
        return {(^body) ^ flip, body};
    endfunction

    function automatic int bit_idx(input logic [27:0] s, input int b);
        int n;
        n = 4;
        for (int j = 0; j < b; j++) n += s[j] ? 2 : 1;
        return n;
    endfunction

    task automatic build(input int pt, input logic [27:0] s, output iq_t q);
        q.delete();
        q.push_back(3'b100);
        case (pt)
            PB:      begin q.push_back(3'b001); q.push_back(3'b001); q.push_back(3'b100); end
            PM:      begin q.push_back(3'b100); q.push_back(3'b001); q.push_back(3'b001); end
            default: begin q.push_back(3'b010); q.push_back(3'b001); q.push_back(3'b010); end
        endcase
        for (int j = 0; j < 28; j++) begin
            if (s[j]) begin q.push_back(3'b001); q.push_back(3'b001); end
            else q.push_back(3'b010);
        end
    endtask

    task automatic send_list(input iq_t q, input int stop, input int ridx,
                             input logic [2:0] rf, input int gmax);
        logic [2:0] f;
        int g;
        for (int i = 0; i < stop; i++) begin
            f = (i == ridx) ? rf : q[i];
            @(negedge clk_i); {three_i, two_i, one_i} = f; ena_i = 1'b0;
            @(negedge clk_i); {three_i, two_i, one_i} = 3'b000; ena_i = 1'b1;
            g = $urandom_range(0, gmax);
            repeat (g) begin @(negedge clk_i); ena_i = 1'b0; end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i); ena_i = 1'b0; {three_i, two_i, one_i} = 3'b000;
        end
    endtask

    iq_t q;
    task automatic sf(input int pt, input logic [27:0] s);
        build(pt, s, q);
        send_list(q, q.size(), -1, 3'b000, 1);
        idle(1);
    endtask

    // ---------------- main sequence ----------------
    logic [27:0] s, sa;
    int v0, e0, pt, ridx;
    bit want_w;
    logic [2:0] rf;

    initial begin
        #1;
        nrst_i = 1'b0;
        m_reset();
        go = 1;
        repeat (3) @(negedge clk_i);
        chk("reset_sample", {8'h0, sample_o}, 32'h0);
        chk("reset_locked", {31'h0, locked_o}, 32'h0);
        chk("reset_flags", {23'h0, valid_o, code_err_o, chan_o, block_start_o, v_o, u_o, c_o,
                            parity_err_o, 1'b0}, 32'h0);
        nrst_i = 1'b1;
        idle(2);

        // Four clean subframes B,W,M,W: one valid on the fourth.
        sa = mk(24'hA5A5A5, 1'b0, 1'b1, 1'b0, 1'b0);
        v0 = obs_valid;
        sf(PB, sa); sf(PW, sa); sf(PM, sa);
        chk("t1_no_valid_before_lock", obs_valid - v0, 0);
        sf(PW, sa);
        chk("t1_one_valid", obs_valid - v0, 1);
        chk("t1_chan", {31'h0, chan_o}, 1);
        chk("t1_block_start", {31'h0, block_start_o}, 0);
        chk("t1_sample", {8'h0, sample_o}, 32'h00A5A5A5);
        chk("t1_vuc", {29'h0, v_o, u_o, c_o}, 32'h2);
        chk("t1_parity_err", {31'h0, parity_err_o}, 0);
        chk("t1_locked", {31'h0, locked_o}, 1);

        // Parity slot flipped while locked.
        v0 = obs_valid;
        sf(PB, mk(24'hA5A5A5, 1'b0, 1'b1, 1'b0, 1'b1));
        chk("t2_valid", obs_valid - v0, 1);
        chk("t2_parity_err", {31'h0, parity_err_o}, 1);
        chk("t2_block_start", {31'h0, block_start_o}, 1);
        chk("t2_locked", {31'h0, locked_o}, 1);

        // Class-3 interval at slot 10 of a W subframe.
        v0 = obs_valid; e0 = obs_err;
        build(PW, sa, q);
        send_list(q, q.size(), bit_idx(sa, 6), 3'b100, 1);
        idle(1);
        chk("t3_code_err", obs_err - e0, 1);
        chk("t3_no_valid", obs_valid - v0, 0);
        chk("t3_unlocked", {31'h0, locked_o}, 0);
        chk("t3_payload_held", {8'h0, sample_o}, 32'h00A5A5A5);
        v0 = obs_valid;
        sf(PB, sa); sf(PW, sa); sf(PM, sa);
        chk("t3_no_early_relock", obs_valid - v0, 0);
        sf(PW, sa);
        chk("t3_relock_valid", obs_valid - v0, 1);
        chk("t3_relocked", {31'h0, locked_o}, 1);

        // M directly after B: channel order violation.
        sf(PB, sa);
        e0 = obs_err;
        sf(PM, sa);
        chk("t4_order_err", obs_err - e0, 1);
        chk("t4_unlocked", {31'h0, locked_o}, 0);

        // Idle timeout while locked.
        sf(PB, sa); sf(PW, sa); sf(PB, sa); sf(PW, sa);
        chk("t5_locked", {31'h0, locked_o}, 1);
        e0 = obs_err;
        idle(70);
        chk("t5_timeout_err", obs_err - e0, 1);
        chk("t5_unlocked", {31'h0, locked_o}, 0);

        // Asynchronous reset at slot 20 of a locked subframe.
        s = mk(24'h3C0F5A, 1'b1, 1'b0, 1'b1, 1'b0);
        sf(PB, s); sf(PW, s); sf(PM, s); sf(PW, s);
        chk("t6_locked", {31'h0, locked_o}, 1);
        build(PB, s, q);
        send_list(q, bit_idx(s, 16), -1, 3'b000, 1);
        @(negedge clk_i);
        ena_i = 1'b0;
        nrst_i = 1'b0;
        m_reset();
        #1;
        chk("t6_reset_sample", {8'h0, sample_o}, 32'h0);
        chk("t6_reset_locked", {31'h0, locked_o}, 0);
        chk("t6_reset_flags", {24'h0, valid_o, code_err_o, chan_o, block_start_o, v_o, u_o, c_o,
                               parity_err_o}, 32'h0);
        idle(3);
        nrst_i = 1'b1;
        v0 = obs_valid;
        sf(PB, s); sf(PW, s); sf(PM, s);
        chk("t6_no_early_valid", obs_valid - v0, 0);
        sf(PW, s);
        chk("t6_valid_after_four", obs_valid - v0, 1);

        // Randomized streams: random data, gaps, corruptions, order faults and long idles.
        want_w = 1'b0;
        for (int n = 0; n < 90; n++) begin
            if (want_w) pt = PW;
            else pt = ($urandom_range(0, 3) == 0) ? PB : PM;
            if ($urandom_range(0, 24) == 0) pt = want_w ? PB : PW;
            s = mk(24'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 7) == 0));
            build(pt, s, q);
            ridx = -1;
            rf = 3'b000;
            if ($urandom_range(0, 9) == 0) begin
                ridx = $urandom_range(0, q.size() - 1);
                rf = 3'($urandom_range(0, 7));
            end
            send_list(q, q.size(), ridx, rf, 3);
            want_w = (pt != PW);
            if ($urandom_range(0, 14) == 0) idle($urandom_range(60, 70));
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
